// File: rtl/trigger_pulse_gen_pkg.sv
// Shared types and default widths for the trigger pulse generator.
package trig_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int NUM_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } state_t;

endpackage

// File: rtl/trigger_pulse_gen_if.sv
// Control/config/status bundle between a sequencer and the trigger pulse generator.
interface trigger_pulse_gen_if import trig_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF,
  parameter int NUM_W = NUM_W_DEF
);

  logic             trigger1;
  logic             abort;
  logic [CNT_W-1:0] delay_cfg;
  logic [CNT_W-1:0] width_cfg;
  logic [CNT_W-1:0] period_cfg;
  logic [NUM_W-1:0] count_cfg;
  logic             pulse_out;
  logic             busy;
  logic             done;
  logic             trig_missed;

  modport master (
    output trigger1, abort, delay_cfg, width_cfg, period_cfg, count_cfg,
    input  pulse_out, busy, done, trig_missed
  );

  modport slave (
    input  trigger1, abort, delay_cfg, width_cfg, period_cfg, count_cfg,
    output pulse_out, busy, done, trig_missed
  );

endinterface

// File: rtl/trigger_pulse_gen_phase_counter.sv
// Shared down-counter timing the DELAY, HIGH and LOW phases.
// A load takes priority; otherwise the count decrements and parks at zero.
// last flags the final cycle of the phase (count == 1).
module phase_counter import trig_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             last
);

  logic [CNT_W-1:0] cnt;

  // load-then-decrement, no wrap below zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/trigger_pulse_gen.sv
// Trigger pulse generator: on an accepted trigger, waits a programmable delay
// and then emits a train of count pulses of programmable width and period.
//
// state | meaning
// IDLE  | waiting for trigger1; done pulses here after a normal finish
// DELAY | counting the trigger-to-first-pulse delay
// HIGH  | pulse_out high for the latched width
// LOW   | gap between pulses, max(period - width, 1) cycles
//
// Width/count of zero are clamped to one and the low time is derived once
// when the trigger is accepted, so later cfg changes never disturb a train.
module trigger_pulse_gen import trig_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF,
  parameter int NUM_W = NUM_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  trigger_pulse_gen_if.slave bus
);

  state_t           state;
  logic [CNT_W-1:0] width_q;
  logic [CNT_W-1:0] low_q;
  logic [NUM_W-1:0] pcnt;

  logic [CNT_W-1:0] width_clamp;
  logic [CNT_W-1:0] low_calc;
  logic [NUM_W-1:0] count_clamp;
  logic             accept;
  logic             pc_load;
  logic [CNT_W-1:0] pc_value;
  logic             pc_last;

  // clamp incoming cfg and decide when/what the phase counter loads
  always_comb begin
    width_clamp = (bus.width_cfg == '0) ? CNT_W'(1) : bus.width_cfg;
    count_clamp = (bus.count_cfg == '0) ? NUM_W'(1) : bus.count_cfg;
    low_calc    = (bus.period_cfg > width_clamp) ? (bus.period_cfg - width_clamp)
                                                 : CNT_W'(1);
    accept      = (state == IDLE) && bus.trigger1 && !bus.abort;
    pc_load     = 1'b0;
    pc_value    = width_q;
    if (!bus.abort) begin
      case (state)
        IDLE: begin
          if (accept) begin
            pc_load  = 1'b1;
            pc_value = (bus.delay_cfg != '0) ? bus.delay_cfg : width_clamp;
          end
        end
        DELAY: begin
          if (pc_last) begin
            pc_load  = 1'b1;
            pc_value = width_q;
          end
        end
        HIGH: begin
          if (pc_last && (pcnt > NUM_W'(1))) begin
            pc_load  = 1'b1;
            pc_value = low_q;
          end
        end
        LOW: begin
          if (pc_last) begin
            pc_load  = 1'b1;
            pc_value = width_q;
          end
        end
        default: begin
          pc_load = 1'b0;
        end
      endcase
    end
  end

  phase_counter #(.CNT_W(CNT_W)) u_phase_counter (
    .clk   (clk),
    .rst   (rst),
    .load  (pc_load),
    .value (pc_value),
    .last  (pc_last)
  );

  // sequencing FSM with registered outputs, latched cfg and pulse counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      bus.pulse_out   <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.trig_missed <= 1'b0;
      width_q         <= '0;
      low_q           <= '0;
      pcnt            <= '0;
    end else begin
      bus.done        <= 1'b0;
      bus.trig_missed <= 1'b0;
      if (bus.abort) begin
        state         <= IDLE;
        bus.pulse_out <= 1'b0;
        bus.busy      <= 1'b0;
      end else begin
        bus.trig_missed <= bus.trigger1 && (state != IDLE);
        case (state)
          IDLE: begin
            if (bus.trigger1) begin
              width_q  <= width_clamp;
              low_q    <= low_calc;
              pcnt     <= count_clamp;
              bus.busy <= 1'b1;
              if (bus.delay_cfg != '0) begin
                state         <= DELAY;
                bus.pulse_out <= 1'b0;
              end else begin
                state         <= HIGH;
                bus.pulse_out <= 1'b1;
              end
            end
          end
          DELAY: begin
            if (pc_last) begin
              state         <= HIGH;
              bus.pulse_out <= 1'b1;
            end
          end
          HIGH: begin
            if (pc_last) begin
              bus.pulse_out <= 1'b0;
              if (pcnt != '0) begin
                pcnt <= pcnt - NUM_W'(1);
              end
              if (pcnt > NUM_W'(1)) begin
                state <= LOW;
              end else begin
                state    <= IDLE;
                bus.busy <= 1'b0;
                bus.done <= 1'b1;
              end
            end
          end
          LOW: begin
            if (pc_last) begin
              state         <= HIGH;
              bus.pulse_out <= 1'b1;
            end
          end
          default: begin
            state         <= IDLE;
            bus.pulse_out <= 1'b0;
            bus.busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trigger_pulse_gen.sv
// Self-checking bench for trigger_pulse_gen: table of cfg vectors plus
// hand-written corner sequences, checked cycle by cycle against a queue of
// expected outputs derived from a closed-form waveform model.
module tb_trigger_pulse_gen;
  import trig_pkg::*;

  localparam int CW = CNT_W_DEF;
  localparam int NW = NUM_W_DEF;

  logic clk = 1'b0;
  logic rst = 1'b1;

  trigger_pulse_gen_if #(.CNT_W(CW), .NUM_W(NW)) bus ();

  trigger_pulse_gen #(.CNT_W(CW), .NUM_W(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pulse;
    logic busy;
    logic done;
    logic missed;
  } exp_t;

  typedef struct {
    int d;
    int w;
    int p;
    int n;
    int exp_end;
    int exp_highs;
  } vec_t;

  exp_t  sb_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  string phase = "reset";

  function automatic int seq_len(int d, int w, int p, int n);
    int wc, nc, lc;
    wc = (w == 0) ? 1 : w;
    nc = (n == 0) ? 1 : n;
    lc = (p > wc) ? p - wc : 1;
    return 1 + d + nc * wc + (nc - 1) * lc;
  endfunction

  // expected outputs k cycles after the trigger cycle
  function automatic exp_t model(int k, int d, int w, int p, int n);
    exp_t e;
    int   wc, lc, st, per, fin, rel;
    e   = '0;
    wc  = (w == 0) ? 1 : w;
    lc  = (p > wc) ? p - wc : 1;
    st  = 1 + d;
    per = wc + lc;
    fin = seq_len(d, w, p, n);
    if (k < fin) begin
      e.busy = 1'b1;
      rel    = k - st;
      if (rel >= 0 && (rel % per) < wc) e.pulse = 1'b1;
    end else if (k == fin) begin
      e.done = 1'b1;
    end
    return e;
  endfunction

  task automatic check(string name, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // advance one cycle, compare against scoreboard, drop one-cycle inputs
  task automatic tick();
    exp_t want, got;
    @(posedge clk);
    #1;
    want = '0;
    if (sb_q.size() > 0) want = sb_q.pop_front();
    got = {bus.pulse_out, bus.busy, bus.done, bus.trig_missed};
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s outputs {pulse,busy,done,missed}: got %b want %b",
               phase, got, want);
    end
    bus.trigger1 = 1'b0;
    bus.abort    = 1'b0;
  endtask

  task automatic start_seq(int d, int w, int p, int n);
    bus.delay_cfg  = CW'(d);
    bus.width_cfg  = CW'(w);
    bus.period_cfg = CW'(p);
    bus.count_cfg  = NW'(n);
    bus.trigger1   = 1'b1;
    for (int k = 1; k <= seq_len(d, w, p, n); k++) sb_q.push_back(model(k, d, w, p, n));
  endtask

  task automatic run_to_done(int budget, output int got_end, output int highs);
    got_end = -1;
    highs   = 0;
    for (int k = 1; k <= budget; k++) begin
      tick();
      if (bus.pulse_out) highs++;
      if (bus.done) begin
        got_end = k;
        break;
      end
    end
  endtask

  vec_t vecs[6];

  initial begin
    int e, h;

    vecs[0] = '{d: 3, w: 2, p: 5, n: 1, exp_end: 6,  exp_highs: 2};
    vecs[1] = '{d: 0, w: 2, p: 5, n: 3, exp_end: 13, exp_highs: 6};
    vecs[2] = '{d: 2, w: 0, p: 0, n: 0, exp_end: 4,  exp_highs: 1};
    vecs[3] = '{d: 2, w: 0, p: 0, n: 2, exp_end: 6,  exp_highs: 2};
    vecs[4] = '{d: 1, w: 3, p: 2, n: 2, exp_end: 9,  exp_highs: 6};
    vecs[5] = '{d: 0, w: 1, p: 4, n: 4, exp_end: 14, exp_highs: 4};

    bus.trigger1   = 1'b0;
    bus.abort      = 1'b0;
    bus.delay_cfg  = '0;
    bus.width_cfg  = '0;
    bus.period_cfg = '0;
    bus.count_cfg  = '0;

    // reset holds everything low, overriding trigger and abort
    phase = "reset";
    tick();
    tick();
    bus.trigger1 = 1'b1;
    bus.abort    = 1'b1;
    tick();
    bus.delay_cfg = CW'(1);
    bus.trigger1  = 1'b1;
    tick();

    // trigger sampled in the first cycle with rst low is accepted
    phase = "first after reset";
    rst = 1'b0;
    start_seq(1, 1, 1, 1);
    run_to_done(20, e, h);
    check("first after reset done offset", e, 3);
    tick();

    foreach (vecs[i]) begin
      phase = $sformatf("vec%0d", i);
      start_seq(vecs[i].d, vecs[i].w, vecs[i].p, vecs[i].n);
      run_to_done(200, e, h);
      check($sformatf("vec%0d done offset", i), e, vecs[i].exp_end);
      check($sformatf("vec%0d high cycles", i), h, vecs[i].exp_highs);
      tick();
      tick();
    end

    // second trigger while busy is dropped and flagged
    phase = "busy trigger";
    start_seq(0, 2, 5, 3);
    tick();
    tick();
    bus.trigger1 = 1'b1;
    sb_q[0].missed = 1'b1;
    run_to_done(50, e, h);
    check("busy trigger done offset", e, 11);

    // trigger on the done cycle starts a new train
    phase = "done retrigger";
    start_seq(1, 1, 1, 2);
    run_to_done(50, e, h);
    check("done retrigger done offset", e, 5);
    tick();

    // abort in LOW, with a simultaneous trigger that must not flag missed
    phase = "abort in low";
    start_seq(0, 2, 5, 3);
    repeat (4) tick();
    bus.abort    = 1'b1;
    bus.trigger1 = 1'b1;
    sb_q.delete();
    repeat (16) tick();

    // rst during HIGH
    phase = "rst in high";
    start_seq(0, 3, 5, 1);
    tick();
    rst = 1'b1;
    sb_q.delete();
    tick();
    tick();
    rst = 1'b0;
    repeat (6) tick();

    // abort and trigger together in IDLE
    phase = "abort+trigger idle";
    bus.abort    = 1'b1;
    bus.trigger1 = 1'b1;
    repeat (5) tick();

    // cfg changes after acceptance do not alter the train
    phase = "cfg change";
    start_seq(3, 2, 5, 2);
    tick();
    tick();
    bus.delay_cfg  = CW'(0);
    bus.width_cfg  = CW'(4);
    bus.period_cfg = CW'(9);
    bus.count_cfg  = NW'(5);
    run_to_done(60, e, h);
    check("cfg change done offset", e, 9);
    check("cfg change high cycles", h, 4);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/trigger_pulse_gen.md
TRIGGER_PULSE_GEN -- requirements
Module: trigger_pulse_gen

Interface
REQ-001 The module SHALL have parameter CNT_W, default 16, giving the width of the delay, width and period counters.
REQ-002 The module SHALL have parameter NUM_W, default 8, giving the width of the pulse-count field.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 trigger1  input  1  single-cycle start pulse from the upstream rising-edge detector.
REQ-006 abort  input  1  level; cancels any sequence in progress.
REQ-007 delay_cfg  input  CNT_W  cycles from trigger acceptance to first pulse.
REQ-008 width_cfg  input  CNT_W  high time of each pulse, in cycles.
REQ-009 period_cfg  input  CNT_W  pulse-to-pulse period, in cycles.
REQ-010 count_cfg  input  NUM_W  number of pulses per sequence.
REQ-011 pulse_out  output  1  registered pulse train.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse on normal sequence completion.
REQ-014 trig_missed  output  1  one-cycle pulse when a trigger is dropped.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, DELAY, HIGH and LOW.
REQ-016 In IDLE, trigger1=1 with abort=0 at cycle T SHALL latch all cfg inputs; cfg changes after T SHALL have no effect on the running sequence.
REQ-017 Zero-valued config SHALL be clamped at latch time: width 0 is treated as 1, and count 0 is treated as 1.
REQ-018 The low time SHALL be max(period-width, 1); the FSM SHALL compute it once, at latch time.
REQ-019 With delay 0, the FSM SHALL enter HIGH at T+1; otherwise it SHALL spend exactly delay cycles in DELAY and enter HIGH at T+1+delay.
REQ-020 pulse_out SHALL equal 1 exactly in the cycles where the state is HIGH; each HIGH phase SHALL last width cycles.
REQ-021 After a HIGH phase that is not the last, the FSM SHALL spend the low time in LOW, then return to HIGH.
REQ-022 After the final HIGH phase, the FSM SHALL go directly to IDLE (no trailing LOW) and assert done for the first IDLE cycle.
REQ-023 A trigger1 received in the IDLE cycle that carries done SHALL be accepted as a new sequence.
REQ-024 Any trigger1 received while busy=1 SHALL be ignored, and trig_missed SHALL pulse in the following cycle.
REQ-025 abort=1 SHALL take priority in every state: next cycle the state is IDLE and pulse_out=0, with no done and no trig_missed.
REQ-026 When trigger1 and abort are both 1 in IDLE, the trigger SHALL be discarded silently.
REQ-027 The counters SHALL be down-counters, load-then-decrement, with no wrap-around; a counter value of 1 SHALL end the phase.
REQ-028 The pulse counter SHALL count remaining pulses, decrement on leaving HIGH, and end the sequence at 1.
REQ-029 All outputs SHALL be driven from flops, with no combinational path from any input to any output.

Reset
REQ-030 While rst=1: state=IDLE, pulse_out=0, busy=0, done=0, trig_missed=0, and all counters and latched cfg are 0.
REQ-031 rst SHALL override abort and trigger1.
REQ-032 rst asserted mid-sequence SHALL terminate the sequence without asserting done.
REQ-033 The first trigger1 accepted is the one sampled in the cycle after rst deasserts.

Structure
REQ-034 Package trig_pkg SHALL hold the state enum type (IDLE/DELAY/HIGH/LOW) and the default CNT_W and NUM_W constants.
REQ-035 One sub-module, phase_counter, SHALL be instantiated for the shared delay/width/low down-counter: inputs load and value; output last.
REQ-036 The pulse-count register SHALL stay in the top-level module.

Verification
REQ-037 Single pulse: delay 3, width 2, period 5, count 1, trigger at T -> pulse_out high at T+4 and T+5; done at T+6; busy high T+1..T+5.
REQ-038 Train: delay 0, width 2, period 5, count 3 -> pulse_out high at T+1..2, T+6..7, T+11..12; done at T+13.
REQ-039 Clamping: width 0, period 0, count 0 -> one 1-cycle pulse at T+1+delay; the same config with count 2 -> pulses separated by exactly 1 low cycle.
REQ-040 Trigger while busy: second trigger1 at T+2 -> trig_missed at T+3; the train is unchanged; back-to-back trigger on the done cycle starts a new sequence.
REQ-041 Abort in LOW, and rst in HIGH -> pulse_out=0 and busy=0 the next cycle, done never asserted; abort+trigger together in IDLE -> no activity.
REQ-042 Mid-sequence cfg change: alter delay/width/period/count at T+2 -> the waveform matches the cfg latched at T.
